// File: rtl/rowbias_shuffler.sv
// Per-row pool of one-hot values, optionally randomised by an LFSR-driven Fisher-Yates shuffle.
// Define ROWBIAS_SHUFFLE_EN to build the shuffler; otherwise the pool is a fixed identity.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module rowbias_shuffler #(
  parameter int          w    = `GRID_LEN,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         update,
  input  logic [w-1:0] rqindex,
  input  logic         reshuffle,
  output logic [w-1:0] busvalue,
  output logic         busy
);

  localparam logic [0:0] SHUFFLE = 1'b0;
  localparam logic [0:0] IDLE    = 1'b1;

  logic [0:0]   state;
  logic [w-1:0] lowbit;

  // Isolating the lowest set bit makes multi-hot requests resolve to the lowest index.
  assign lowbit = rqindex & (~rqindex + w'(1));
  assign busy   = (state == SHUFFLE);

`ifdef ROWBIAS_SHUFFLE_EN
  localparam int             IW     = (w > 1) ? $clog2(w) : 1;
  localparam logic [IW-1:0]  ISTART = IW'(w - 1);
  localparam logic [IW-1:0]  ILAST  = IW'(1);

  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [IW:0]   span;
  logic [15:0]   lfsr;
  logic [w-1:0]  pool [w];
  logic [w-1:0]  sel;

  // Scaling an 8-bit random value by (i+1) keeps j within 0..i without a divider.
  assign span = {1'b0, i} + (IW+1)'(1);
  assign j    = IW'(({{(IW+1){1'b0}}, lfsr[7:0]} * {8'd0, span}) >> 8);

  always_comb begin
    sel = '0;
    for (int b = 0; b < w; b++) begin
      if (lowbit[b]) sel = sel | pool[b];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SHUFFLE;
      i        <= ISTART;
      lfsr     <= SEED;
      busvalue <= '0;
      for (int k = 0; k < w; k++) pool[k] <= w'(1) << k;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (state == SHUFFLE) begin
        // A swap with j == i writes each entry back to itself, so no special case.
        pool[i] <= pool[j];
        pool[j] <= pool[i];
        if (i <= ILAST) state <= IDLE;
        else            i     <= i - IW'(1);
      end else begin
        if (update) busvalue <= sel;
        if (reshuffle) begin
          state <= SHUFFLE;
          i     <= ISTART;
        end
      end
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = reshuffle ^ (^SEED);

  // With an identity pool the read reduces to the isolated request bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SHUFFLE;
      busvalue <= '0;
    end else begin
      state <= IDLE;
      if (update && state == IDLE) busvalue <= lowbit;
    end
  end
`endif

endmodule
